reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
- Shares a small bank of 32-bit registers between two write requesters, A and B. A fair round-robin arbiter picks the writer.
- A combinational read port allows any register to be read back.
- A saturating collision counter records contention for debug.
- Sits between two datapath masters, for example a loader and an ALU writeback, and the storage registers.

Parameters:
- DATA_W, 32, width of each register and of the write/read data.
- NUM_REGS, 4, number of registers in the bank.
- ADDR_W, 2, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- COLL_W, 16, width of the collision counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- n_rst  input  1  asynchronous active-low reset.
- valid_a  input  1  requester A write request.
- addr_a  input  ADDR_W  requester A target register.
- wdata_a  input  DATA_W  requester A write data.
- ready_a  output  1  A's write is accepted at this rising edge.
- valid_b  input  1  requester B write request.
- addr_b  input  ADDR_W  requester B target register.
- wdata_b  input  DATA_W  requester B write data.
- ready_b  output  1  B's write is accepted at this rising edge.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  contents of register rd_addr.
- coll_cnt  output  COLL_W  count of cycles with both valid_a and valid_b high.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on n_rst.
- Reset state:
  - All registers = 0.
  - Priority pointer = A.
  - coll_cnt = 0.
  - ready_a and ready_b are combinational, so they are 0 during reset regardless of valid.
  - rd_data reflects the cleared bank (0).
- Handshake:
  - A requester asserts valid_x with stable addr_x/wdata_x until it sees ready_x=1 at a rising edge.
  - Transfer occurs on the edge where valid_x && ready_x.
  - ready_x is a combinational function of valid_a, valid_b and the pointer, within the same cycle.
  - Deasserting valid before ready is allowed (request withdrawn, nothing written).
- Arbitration:
  - Only A valid: ready_a=1, ready_b=0.
  - Only B valid: ready_b=1, ready_a=0.
  - Both valid: the pointer owner gets ready=1; the other gets 0.
  - At most one ready is high in any cycle.
- Pointer update:
  - On every accepted transfer, the pointer moves to the other requester (A granted -> B, B granted -> A).
  - No transfer: pointer unchanged.
  - Result: continuous contention alternates A, B, A, B...
- Write:
  - On the accepting edge, reg[addr_winner] <= wdata_winner.
  - An address >= NUM_REGS is ignored (no write), but the handshake still completes and the pointer still rotates.
- Read:
  - rd_data = reg[rd_addr], combinational. An out-of-range rd_addr returns 0.
  - Read during write to the same address returns the old value in that cycle and the new value after the edge.
- Same address from both requesters: only the winner writes. The loser writes on a later edge once granted, so the loser's value is the final value.
- Collision counter:
  - Increments by 1 on each rising edge where valid_a && valid_b, regardless of address.
  - Saturates at all-ones and stays there until reset.
- Reset mid-operation:
  - The asynchronous clear of the bank, pointer and counter takes effect immediately.
  - Any pending request is lost; requesters must re-present after n_rst rises.
  - The first arbitration after reset favours A.
- No latency beyond one edge: data written at edge N is visible on rd_data right after edge N.

Test Plan:
- Reset check: hold n_rst=0 for 7 ns with random valid -> ready_a=ready_b=0, rd_data=0 for all addresses, coll_cnt=0.
- Single writer, A only: valid_a=1, addr_a=1, wdata_a=32'h0000_000A -> ready_a=1 that cycle. After the edge, rd_addr=1 gives 32'h0000_000A and coll_cnt stays 0.
- Contention: both valid, A writes addr 2 = 32'd20 and B writes addr 3 = 32'd100.
  - Cycle 1: ready_a only.
  - Cycle 2: ready_b only.
  - After cycle 2: reg2=20, reg3=100, coll_cnt=1.
- Same address, round-robin: A and B both hold valid continuously, both targeting addr 0, A with 32'd128 and B with 32'd8192, each re-presenting after acceptance.
  - Grants alternate A, B, A, B.
  - After four edges, reg0=8192.
  - coll_cnt=4.
- Saturation: build with COLL_W=4 and hold both valid for 20 cycles -> coll_cnt stops at 4'hF.
- Reset mid-operation: during contention, pulse n_rst low between edges -> bank, coll_cnt and ready outputs clear at once. After release, with both valid, the first grant goes to A.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Brief    : Register bank shared by two write requesters through a
//            round-robin arbiter, with a combinational read port and a
//            saturating collision counter.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int COLL_W   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              valid_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ready_a,
    input  logic              valid_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ready_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [COLL_W-1:0] coll_cnt
);

    localparam int c_CMP_W = ADDR_W + 1;

    typedef enum logic [0:0] {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    ptr_e              ptr_q;
    ptr_e              ptr_d;
    logic [COLL_W-1:0] coll_q;
    logic [COLL_W-1:0] coll_d;
    logic [DATA_W-1:0] bank_q [NUM_REGS];

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_wr_en;
    logic              w_addr_ok;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    // Grants are masked while n_rst is low so no handshake completes in reset.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        ptr_d     = ptr_q;
        if (n_rst) begin
            if (valid_a && (!valid_b || (ptr_q == PTR_A))) begin
                w_grant_a = 1'b1;
            end else if (valid_b) begin
                w_grant_b = 1'b1;
            end
        end
        if (w_grant_a) begin
            ptr_d = PTR_B;
        end else if (w_grant_b) begin
            ptr_d = PTR_A;
        end
    end

    assign ready_a   = w_grant_a;
    assign ready_b   = w_grant_b;
    assign w_wr_en   = w_grant_a | w_grant_b;
    assign w_wr_addr = w_grant_a ? addr_a  : addr_b;
    assign w_wr_data = w_grant_a ? wdata_a : wdata_b;
    // Extra bit keeps the compare exact when NUM_REGS == 2**ADDR_W.
    assign w_addr_ok = ({1'b0, w_wr_addr} < c_CMP_W'(NUM_REGS));

    always_comb begin
        coll_d = coll_q;
        if (valid_a && valid_b && (coll_q != {COLL_W{1'b1}})) begin
            coll_d = coll_q + COLL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q  <= PTR_A;
            coll_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            coll_q <= coll_d;
        end
    end

    assign coll_cnt = coll_q;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            logic w_we;
            assign w_we = w_wr_en && w_addr_ok && (w_wr_addr == ADDR_W'(i));

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    bank_q[i] <= '0;
                end else if (w_we) begin
                    bank_q[i] <= w_wr_data;
                end
            end
        end
    endgenerate

    // Out-of-range read addresses match no register and fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = bank_q[i];
            end
        end
    end

endmodule
`default_nettype wire
